// File: rtl/fc_stream_serializer_pkg.sv
// Shared types and the requantization function for the FC stream serializer.
package fc_stream_serializer_pkg;

  localparam int DW_MAX  = 32;
  localparam int ACC_MAX = 64;

  typedef enum logic {IDLE, STREAM} state_e;

  typedef struct packed {
    logic signed [DW_MAX-1:0] val;
    logic                     sat;
  } requant_t;

  // Floor shift, optional ReLU, then saturate into a dw-bit signed range.
  function automatic requant_t sat_requant(input logic signed [ACC_MAX-1:0] acc,
                                           input int frac, input bit relu, input int dw);
    logic signed [ACC_MAX-1:0] v, one, vmax, vmin;
    requant_t r;
    one  = 1;
    v    = acc >>> frac;
    if (relu && v < 0) v = '0;
    vmax = (one <<< (dw - 1)) - one;
    vmin = -(one <<< (dw - 1));
    r.sat = 1'b0;
    r.val = DW_MAX'(v);
    if (v > vmax) begin
      r.val = DW_MAX'(vmax);
      r.sat = 1'b1;
    end else if (v < vmin) begin
      r.val = DW_MAX'(vmin);
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fc_stream_serializer_requant.sv
// One-element combinational requantizer used per lane at vector acceptance.
module fc_requant
  import fc_stream_serializer_pkg::*;
#(
  parameter int ACC_WIDTH  = 32,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int RELU_EN    = 1
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  output logic signed [DATA_WIDTH-1:0] val,
  output logic                         sat
);

  requant_t r;

  assign r   = sat_requant(ACC_MAX'(acc), FRAC_BITS, RELU_EN != 0, DATA_WIDTH);
  assign val = DATA_WIDTH'(r.val);
  assign sat = r.sat;

endmodule

// File: rtl/fc_stream_serializer.sv
// Vector-to-element serializer with ACTIVE/PENDING double buffering between FC layers.
module fc_stream_serializer
  import fc_stream_serializer_pkg::*;
#(
  parameter int NUM_ELEMS  = 10,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int FRAC_BITS  = 8,
  parameter int RELU_EN    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [ACC_WIDTH-1:0]  in_data [NUM_ELEMS],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_last,
  output logic                         out_sat,
  output logic                         busy
);

  localparam int IDX_W = $clog2(NUM_ELEMS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

  logic signed [DATA_WIDTH-1:0] rq_val [NUM_ELEMS];
  logic [NUM_ELEMS-1:0]         rq_sat;

  for (genvar i = 0; i < NUM_ELEMS; i++) begin : g_rq
    fc_requant #(
      .ACC_WIDTH (ACC_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .FRAC_BITS (FRAC_BITS),
      .RELU_EN   (RELU_EN)
    ) u_rq (
      .acc(in_data[i]),
      .val(rq_val[i]),
      .sat(rq_sat[i])
    );
  end

  state_e                       state_q, state_d;
  logic signed [DATA_WIDTH-1:0] act_val_q [NUM_ELEMS], act_val_d [NUM_ELEMS];
  logic signed [DATA_WIDTH-1:0] pend_val_q [NUM_ELEMS], pend_val_d [NUM_ELEMS];
  logic [NUM_ELEMS-1:0]         act_sat_q, act_sat_d, pend_sat_q, pend_sat_d;
  logic                         pend_full_q, pend_full_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic                         out_sat_q, out_sat_d;
  logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                         hs, last_hs, accept;

  always_comb begin
    state_d     = state_q;
    act_val_d   = act_val_q;
    act_sat_d   = act_sat_q;
    pend_val_d  = pend_val_q;
    pend_sat_d  = pend_sat_q;
    pend_full_d = pend_full_q;
    idx_d       = idx_q;

    hs      = (state_q == STREAM) && out_ready;
    last_hs = hs && (idx_q == LAST_IDX);
    accept  = in_valid && !pend_full_q;

    if (hs) idx_d = last_hs ? '0 : idx_q + 1'b1;

    if (last_hs) begin
      if (pend_full_q) begin
        act_val_d   = pend_val_q;
        act_sat_d   = pend_sat_q;
        pend_full_d = 1'b0;
      end else begin
        state_d = IDLE;
      end
    end

    // accept never coincides with a PENDING->ACTIVE move: it needs pend_full_q low
    if (accept) begin
      if (state_q == IDLE || last_hs) begin
        act_val_d = rq_val;
        act_sat_d = rq_sat;
        idx_d     = '0;
        state_d   = STREAM;
      end else begin
        pend_val_d  = rq_val;
        pend_sat_d  = rq_sat;
        pend_full_d = 1'b1;
      end
    end

    out_valid_d = (state_d == STREAM);
    out_data_d  = out_valid_d ? act_val_d[idx_d] : '0;
    out_sat_d   = out_valid_d && act_sat_d[idx_d];
    out_last_d  = out_valid_d && (idx_d == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      act_val_q   <= '{default: '0};
      pend_val_q  <= '{default: '0};
      act_sat_q   <= '0;
      pend_sat_q  <= '0;
      pend_full_q <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_val_q   <= act_val_d;
      pend_val_q  <= pend_val_d;
      act_sat_q   <= act_sat_d;
      pend_sat_q  <= pend_sat_d;
      pend_full_q <= pend_full_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign in_ready  = !pend_full_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sat   = out_sat_q;
  assign busy      = (state_q == STREAM) || pend_full_q;

endmodule

// File: tb/tb_fc_stream_serializer.sv
// Directed bench for fc_stream_serializer; a second instance runs with ReLU disabled.
module tb_fc_stream_serializer;

  localparam int N = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic signed [31:0] in_data [N];

  logic in_ready, out_valid, out_last, out_sat, busy;
  logic signed [15:0] out_data;
  logic in_ready_0, out_valid_0, out_last_0, out_sat_0, busy_0;
  logic signed [15:0] out_data_0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fc_stream_serializer #(.NUM_ELEMS(N), .DATA_WIDTH(16), .ACC_WIDTH(32), .FRAC_BITS(8), .RELU_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_sat(out_sat), .busy(busy)
  );

  fc_stream_serializer #(.NUM_ELEMS(N), .DATA_WIDTH(16), .ACC_WIDTH(32), .FRAC_BITS(8), .RELU_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_0), .in_data(in_data),
    .out_valid(out_valid_0), .out_ready(out_ready), .out_data(out_data_0), .out_last(out_last_0),
    .out_sat(out_sat_0), .busy(busy_0)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int base);
    for (int i = 0; i < N; i++) in_data[i] = (base + i) * 256;
  endtask

  task automatic check_el(input string tag, input int d, input bit last);
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_data"}, int'(out_data), d);
    chk({tag, "_last"}, int'(out_last), int'(last));
  endtask

  task automatic send(input int base);
    set_vec(base);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  int e1d [N] = '{0, 32767, 0, 0, 0, 0, 0, 0, 0, 0};
  int e1s [N] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
  int e0d [N] = '{-2, 32767, -32768, 0, 0, 0, 0, 0, 0, 0};
  int e0s [N] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    int e;
    for (int i = 0; i < N; i++) in_data[i] = 0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_sat", int'(out_sat), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // 1: basic requant and framing
    in_data[0] = 32'h0000_1234;
    in_data[1] = 76800;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      check_el("t1", (k == 0) ? 18 : (k == 1) ? 300 : 0, k == N - 1);
      chk("t1_busy", int'(busy), 1);
      tick();
    end
    chk("t1_end_valid", int'(out_valid), 0);
    chk("t1_end_busy", int'(busy), 0);

    // 2: ReLU and saturation, both ReLU settings
    for (int i = 0; i < N; i++) in_data[i] = 0;
    in_data[0] = -512;
    in_data[1] = 32'h7FFF_FFFF;
    in_data[2] = 32'h8000_0000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk("t2_relu_data", int'(out_data), e1d[k]);
      chk("t2_relu_sat", int'(out_sat), e1s[k]);
      chk("t2_norelu_valid", int'(out_valid_0), 1);
      chk("t2_norelu_data", int'(out_data_0), e0d[k]);
      chk("t2_norelu_sat", int'(out_sat_0), e0s[k]);
      tick();
    end
    chk("t2_end_valid", int'(out_valid), 0);

    // 3: back-to-back A, B, C with no bubbles
    set_vec(1);
    in_valid = 1'b1;
    tick();
    for (int k = 0; k < 3 * N; k++) begin
      check_el("t3", k + 1, (k % N) == N - 1);
      chk("t3_in_ready", int'(in_ready), (k == 0 || k == N || k >= 2 * N) ? 1 : 0);
      if (k == 0) set_vec(11);
      if (k == 1) set_vec(21);
      if (k == N + 1) in_valid = 1'b0;
      tick();
    end
    chk("t3_end_valid", int'(out_valid), 0);

    // 4: out_ready pattern 1,0,0,1,...
    send(40);
    e = 0;
    for (int c = 0; c < 40 && e < N; c++) begin
      check_el("t4", 40 + e, e == N - 1);
      out_ready = (c % 3 == 0);
      tick();
      if (out_ready) e++;
    end
    out_ready = 1'b1;
    chk("t4_count", e, N);
    chk("t4_end_valid", int'(out_valid), 0);

    // 5: new vector on the last handshake with PENDING empty
    send(50);
    for (int k = 0; k < 2 * N; k++) begin
      check_el("t5", 50 + k, (k % N) == N - 1);
      if (k == N - 1) begin
        chk("t5_in_ready", int'(in_ready), 1);
        set_vec(60);
        in_valid = 1'b1;
      end
      if (k == N) in_valid = 1'b0;
      tick();
    end
    chk("t5_end_valid", int'(out_valid), 0);

    // 6: reset mid-frame with PENDING full
    set_vec(70);
    in_valid = 1'b1;
    tick();
    check_el("t6", 70, 1'b0);
    set_vec(80);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      check_el("t6", 70 + k, 1'b0);
      tick();
    end
    check_el("t6", 75, 1'b0);
    chk("t6_pre_busy", int'(busy), 1);
    chk("t6_pre_in_ready", int'(in_ready), 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_in_ready", int'(in_ready), 1);
    chk("t6_rst_data", int'(out_data), 0);
    send(90);
    for (int k = 0; k < N; k++) begin
      check_el("t6_new", 90 + k, k == N - 1);
      tick();
    end
    chk("t6_end_valid", int'(out_valid), 0);
    chk("t6_end_busy", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
